wdt_rst_seq: RTL and testbench
==============================

# wdt_rst_seq

Watchdog reset sequencer on the 8-bit APB peripheral bus. Takes the single-cycle bite from the watchdog timer plus software reset requests, optionally raises a warning interrupt with a grace window, then drives a staged system/peripheral reset. It also records the reset cause and bite count, and clears the watchdog when a sequence completes.

## Interface
- `WIDTH`, 8: APB address/data width.
- `STAGGER`, 4: cycles `periph_rst_o` stays high after `sysrst_o` falls; must be ≥1.
- `pclk_i` in 1: clock; all logic is on the rising edge.
- `prst_n_i` in 1: reset, asynchronous, active-low; deassertion is synchronised by the system.
- `psel_i` in 1: APB select.
- `penable_i` in 1: APB enable.
- `pwrite_i` in 1: 1 = write.
- `paddr_i` in WIDTH: register address.
- `pwdata_i` in WIDTH: write data.
- `bite_i` in 1: watchdog expiry pulse.
- `pready_o` out 1: APB ready, registered.
- `prdata_o` out WIDTH: read data, registered.
- `irq_o` out 1: warning interrupt, level.
- `sysrst_o` out 1: core reset request, active-high.
- `periph_rst_o` out 1: peripheral reset request, active-high.
- `wdt_clr_o` out 1: one-cycle watchdog counter clear.

## Operation
**Registers.** Unmapped addresses read 0 and ignore writes.
- 0xA4 CTRL: bit0 `seq_en`, reset 1. bit1 `sw_rst`: writing 1 requests a reset; the bit self-clears and reads 0.
- 0xA5 HOLD: reset 16. A value of 0 behaves as 1.
- 0xA6 GRACE: reset 32.
- 0xA7 STATUS (read-only except clear): [7:4] bite count, saturates at 15. bit1 last cause = software. bit0 last cause = watchdog. Any write clears STATUS to 0.
- 0xA8 ACK: writing 0x5A while in WARN cancels the sequence. Any other write, or a write outside WARN, has no effect. Reads 0.

**FSM**, states IDLE, WARN, HOLD, STAG, with an 8-bit down-counter `cnt`:
- IDLE, `bite_i` with `seq_en`=1:
  - go to WARN, `cnt` = GRACE.
  - bite count +1; STATUS[1:0] = 01.
- IDLE, `bite_i` with `seq_en`=0: bite count +1 only, stay in IDLE.
- IDLE, `sw_rst` write: go to HOLD, `cnt` = HOLD−1, STATUS[1:0] = 10.
- IDLE, bite and `sw_rst` on the same edge: the watchdog path wins and the software request is dropped.
- WARN: `irq_o`=1.
  - ACK 0x5A → IDLE, pulse `wdt_clr_o`.
  - Else if `cnt`==0 → HOLD, `cnt` = HOLD−1.
  - Else `cnt`−1.
  - ACK on the same edge as `cnt`==0: ACK wins.
- HOLD: `sysrst_o`=`periph_rst_o`=1. When `cnt`==0 → STAG, `cnt` = STAGGER−1. Else `cnt`−1.
- STAG: `periph_rst_o`=1, `sysrst_o`=0. When `cnt`==0 → IDLE and pulse `wdt_clr_o`.
- In WARN, HOLD and STAG, `bite_i` and `sw_rst` are ignored and not counted.
- HOLD, GRACE and `seq_en` are sampled only when a state is entered; writes made mid-sequence apply to the next sequence.
- APB stays fully operational in every state.

## Timing
- Reset values: `pready_o`, `prdata_o`, `irq_o`, `sysrst_o`, `periph_rst_o`, `wdt_clr_o` all 0; state IDLE. Async assertion mid-sequence returns to IDLE immediately and drops all outputs.
- APB:
  - `pready_o` rises on the edge after `psel_i`&`penable_i` is first sampled and falls on the following edge, so each transfer takes 3 cycles.
  - A write commits, and `prdata_o` updates, on the edge where `psel_i`&`penable_i`&!`pready_o` is sampled.
  - `prdata_o` holds its value between reads.
- All FSM outputs are registered and change on the edge that enters the state.
- Durations:
  - `bite_i` seen at edge E: `irq_o` rises at E and is high GRACE+1 cycles; `sysrst_o` rises at E+GRACE+1.
  - `sysrst_o` is high exactly max(HOLD,1) cycles.
  - `periph_rst_o` stays high STAGGER cycles longer.
  - `wdt_clr_o` is high for exactly 1 cycle at IDLE re-entry.

## Configuration
- `WDT_RST_SEQ_WARN_EN` defined: WARN state, GRACE and ACK registers, and `irq_o` are present as described.
- Not defined:
  - A bite in IDLE with `seq_en`=1 goes directly to HOLD.
  - `irq_o` is tied 0.
  - GRACE and ACK read 0 and ignore writes.
  - All other behaviour is unchanged.

## Test plan
- Reset, then read every register → CTRL 0x01, HOLD 0x10, GRACE 0x20, STATUS 0x00; all outputs 0.
- GRACE=3, HOLD=5, pulse `bite_i` → `irq_o` high 4 cycles, `sysrst_o` high 5, `periph_rst_o` high 9, one `wdt_clr_o` pulse, STATUS 0x11.
- Bite, then write ACK 0x5A during WARN → no reset, `irq_o` drops, `wdt_clr_o` pulse. Same bench with ACK 0x33 → full reset sequence runs.
- Write CTRL=0x03 with HOLD=0 → `sysrst_o` high 1 cycle, STATUS[1:0]=10, CTRL reads 0x01.
- `seq_en`=0, 17 bites → no reset outputs, STATUS[7:4]=15. Write STATUS → 0x00.
- `bite_i` and `sw_rst` on the same edge → watchdog path; assert `prst_n_i` during HOLD → outputs 0 immediately and registers back to reset values.

Source files
------------

// File: rtl/wdt_rst_seq_if.sv
// APB slave bus bundle for the watchdog reset sequencer.
interface wdt_rst_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             psel;
    logic             penable;
    logic             pwrite;
    logic [WIDTH-1:0] paddr;
    logic [WIDTH-1:0] pwdata;
    logic             pready;
    logic [WIDTH-1:0] prdata;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, prdata
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, prdata
    );
endinterface

// File: rtl/wdt_rst_seq.sv
// Watchdog reset sequencer: stages sysrst/periph_rst after a bite or software request.
// Define WDT_RST_SEQ_WARN_EN to add the WARN stage, GRACE/ACK registers and irq_o.
module wdt_rst_seq #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned STAGGER = 4
) (
    input  logic         pclk_i,
    input  logic         prst_n_i,
    wdt_rst_seq_if.slave apb,
    input  logic         bite_i,
    output logic         irq_o,
    output logic         sysrst_o,
    output logic         periph_rst_o,
    output logic         wdt_clr_o
);
    localparam logic [WIDTH-1:0] AddrCtrl   = WIDTH'(8'hA4);
    localparam logic [WIDTH-1:0] AddrHold   = WIDTH'(8'hA5);
    localparam logic [WIDTH-1:0] AddrStatus = WIDTH'(8'hA7);
`ifdef WDT_RST_SEQ_WARN_EN
    localparam logic [WIDTH-1:0] AddrGrace  = WIDTH'(8'hA6);
    localparam logic [WIDTH-1:0] AddrAck    = WIDTH'(8'hA8);
`endif

    typedef enum logic [1:0] {StIdle, StWarn, StHold, StStag} state_e;

    state_e           state_q;
    logic [7:0]       cnt_q;
    logic             pready_q;
    logic [WIDTH-1:0] prdata_q;
    logic [WIDTH-1:0] rdata;
    logic             seq_en_q;
    logic [WIDTH-1:0] hold_q;
    logic [3:0]       bite_cnt_q, bite_cnt_d;
    logic [1:0]       cause_q, cause_d;
    logic             sysrst_q, periph_q, clr_q;
    logic             access, wr_en, rd_en, sw_req;
    logic             bite_idle, start_bite, start_sw;
    logic [7:0]       hold_load;
`ifdef WDT_RST_SEQ_WARN_EN
    logic [WIDTH-1:0] grace_q;
    logic             irq_q;
    logic             ack_hit;
`endif

    assign access     = apb.psel & apb.penable & ~pready_q;
    assign wr_en      = access & apb.pwrite;
    assign rd_en      = access & ~apb.pwrite;
    assign sw_req     = wr_en & (apb.paddr == AddrCtrl) & apb.pwdata[1];
    assign bite_idle  = (state_q == StIdle) & bite_i;
    assign start_bite = bite_idle & seq_en_q;
    // A simultaneous bite always takes precedence; the software request is dropped.
    assign start_sw   = (state_q == StIdle) & sw_req & ~bite_i;
    assign hold_load  = (hold_q == '0) ? 8'd0 : 8'(hold_q - WIDTH'(1));
`ifdef WDT_RST_SEQ_WARN_EN
    assign ack_hit    = (state_q == StWarn) & wr_en & (apb.paddr == AddrAck) &
                        (apb.pwdata == WIDTH'(8'h5A));
    assign irq_o      = irq_q;
`else
    assign irq_o      = 1'b0;
`endif

    assign apb.pready   = pready_q;
    assign apb.prdata   = prdata_q;
    assign sysrst_o     = sysrst_q;
    assign periph_rst_o = periph_q;
    assign wdt_clr_o    = clr_q;

    always_comb begin
        rdata = '0;
        case (apb.paddr)
            AddrCtrl:   rdata = WIDTH'(seq_en_q);
            AddrHold:   rdata = hold_q;
`ifdef WDT_RST_SEQ_WARN_EN
            AddrGrace:  rdata = grace_q;
`endif
            AddrStatus: rdata = WIDTH'({bite_cnt_q, 2'b00, cause_q});
            default:    rdata = '0;
        endcase
    end

    // STATUS clear happens first so a bite on the same edge is still logged.
    always_comb begin
        bite_cnt_d = bite_cnt_q;
        cause_d    = cause_q;
        if (wr_en && (apb.paddr == AddrStatus)) begin
            bite_cnt_d = '0;
            cause_d    = '0;
        end
        if (bite_idle && (bite_cnt_d != 4'hF)) bite_cnt_d = bite_cnt_d + 4'd1;
        if (start_bite)    cause_d = 2'b01;
        else if (start_sw) cause_d = 2'b10;
    end

    always_ff @(posedge pclk_i or negedge prst_n_i) begin
        if (!prst_n_i) begin
            pready_q   <= 1'b0;
            prdata_q   <= '0;
            seq_en_q   <= 1'b1;
            hold_q     <= WIDTH'(16);
`ifdef WDT_RST_SEQ_WARN_EN
            grace_q    <= WIDTH'(32);
`endif
            bite_cnt_q <= '0;
            cause_q    <= '0;
        end else begin
            pready_q   <= access;
            bite_cnt_q <= bite_cnt_d;
            cause_q    <= cause_d;
            if (rd_en) prdata_q <= rdata;
            if (wr_en) begin
                case (apb.paddr)
                    AddrCtrl:  seq_en_q <= apb.pwdata[0];
                    AddrHold:  hold_q   <= apb.pwdata;
`ifdef WDT_RST_SEQ_WARN_EN
                    AddrGrace: grace_q  <= apb.pwdata;
`endif
                    default:   ;
                endcase
            end
        end
    end

    always_ff @(posedge pclk_i or negedge prst_n_i) begin
        if (!prst_n_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            sysrst_q <= 1'b0;
            periph_q <= 1'b0;
            clr_q    <= 1'b0;
`ifdef WDT_RST_SEQ_WARN_EN
            irq_q    <= 1'b0;
`endif
        end else begin
            clr_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_bite) begin
`ifdef WDT_RST_SEQ_WARN_EN
                        state_q <= StWarn;
                        cnt_q   <= 8'(grace_q);
                        irq_q   <= 1'b1;
`else
                        state_q  <= StHold;
                        cnt_q    <= hold_load;
                        sysrst_q <= 1'b1;
                        periph_q <= 1'b1;
`endif
                    end else if (start_sw) begin
                        state_q  <= StHold;
                        cnt_q    <= hold_load;
                        sysrst_q <= 1'b1;
                        periph_q <= 1'b1;
                    end
                end
`ifdef WDT_RST_SEQ_WARN_EN
                StWarn: begin
                    if (ack_hit) begin
                        state_q <= StIdle;
                        irq_q   <= 1'b0;
                        clr_q   <= 1'b1;
                    end else if (cnt_q == 8'd0) begin
                        state_q  <= StHold;
                        cnt_q    <= hold_load;
                        irq_q    <= 1'b0;
                        sysrst_q <= 1'b1;
                        periph_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
`endif
                StHold: begin
                    if (cnt_q == 8'd0) begin
                        state_q  <= StStag;
                        cnt_q    <= 8'(STAGGER - 1);
                        sysrst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                StStag: begin
                    if (cnt_q == 8'd0) begin
                        state_q  <= StIdle;
                        periph_q <= 1'b0;
                        clr_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_wdt_rst_seq.sv
// Directed self-checking bench for wdt_rst_seq; expectations follow WDT_RST_SEQ_WARN_EN.
module tb_wdt_rst_seq;
`ifdef WDT_RST_SEQ_WARN_EN
    localparam bit WarnEn = 1'b1;
`else
    localparam bit WarnEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic prst_n;
    logic bite;
    logic irq, sysrst, periph, clr;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   c_irq = 0, c_sys = 0, c_per = 0, c_clr = 0;
    int   s_irq, s_sys, s_per, s_clr;

    wdt_rst_seq_if #(.WIDTH(8)) apb ();

    wdt_rst_seq #(.WIDTH(8), .STAGGER(4)) dut (
        .pclk_i       (clk),
        .prst_n_i     (prst_n),
        .apb          (apb),
        .bite_i       (bite),
        .irq_o        (irq),
        .sysrst_o     (sysrst),
        .periph_rst_o (periph),
        .wdt_clr_o    (clr)
    );

    always #5 clk = ~clk;

    // High-cycle counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (irq    === 1'b1) c_irq <= c_irq + 1;
        if (sysrst === 1'b1) c_sys <= c_sys + 1;
        if (periph === 1'b1) c_per <= c_per + 1;
        if (clr    === 1'b1) c_clr <= c_clr + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        s_irq = c_irq; s_sys = c_sys; s_per = c_per; s_clr = c_clr;
    endtask

    task automatic check_counts(input string tag, input int e_irq, input int e_sys,
                                input int e_per, input int e_clr);
        check_eq({tag, "_irq"}, c_irq - s_irq, e_irq);
        check_eq({tag, "_sys"}, c_sys - s_sys, e_sys);
        check_eq({tag, "_per"}, c_per - s_per, e_per);
        check_eq({tag, "_clr"}, c_clr - s_clr, e_clr);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apb_write(input logic [7:0] addr, input logic [7:0] data);
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
        apb.paddr = addr; apb.pwdata = data;
        @(posedge clk); #1 apb.penable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 apb.psel = 1'b0; apb.penable = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] addr, output logic [7:0] data);
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = addr;
        @(posedge clk); #1 apb.penable = 1'b1;
        @(posedge clk); #1;
        check_eq("pready_hi", apb.pready, 1'b1);
        data = apb.prdata;
        @(posedge clk); #1 apb.psel = 1'b0; apb.penable = 1'b0;
        check_eq("pready_lo", apb.pready, 1'b0);
    endtask

    task automatic pulse_bite();
        bite = 1'b1;
        @(posedge clk); #1 bite = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_irq"}, irq, 1'b0);
        check_eq({tag, "_sys"}, sysrst, 1'b0);
        check_eq({tag, "_per"}, periph, 1'b0);
        check_eq({tag, "_clr"}, clr, 1'b0);
        check_eq({tag, "_prdy"}, apb.pready, 1'b0);
    endtask

    task automatic check_reset_regs(input string tag);
        logic [7:0] rd;
        apb_read(8'hA4, rd); check_eq({tag, "_ctrl"}, rd, 8'h01);
        apb_read(8'hA7, rd); check_eq({tag, "_status"}, rd, 8'h00);
        apb_read(8'hA6, rd); check_eq({tag, "_grace"}, rd, WarnEn ? 8'h20 : 8'h00);
        apb_read(8'hA5, rd); check_eq({tag, "_hold"}, rd, 8'h10);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        logic [7:0] rd;
        int k;
        prst_n = 1'b0; bite = 1'b0;
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
        apb.paddr = '0; apb.pwdata = '0;
        wait_cycles(3);
        check_outputs_zero("rst");
        check_eq("rst_prdata", apb.prdata, 8'h00);
        prst_n = 1'b1;
        wait_cycles(1);

        // Reset register values; last read is HOLD so prdata holds 0x10.
        apb_read(8'hA8, rd); check_eq("ack_rd", rd, 8'h00);
        apb_read(8'h00, rd); check_eq("unmapped_rd", rd, 8'h00);
        check_reset_regs("init");

        // GRACE=3, HOLD=5 bite sequence.
        apb_write(8'hA6, 8'h03);
        apb_write(8'hA5, 8'h05);
        check_eq("prdata_hold", apb.prdata, 8'h10);
        apb_read(8'hA6, rd); check_eq("grace_wr", rd, WarnEn ? 8'h03 : 8'h00);
        snap();
        pulse_bite();
        check_eq("bite_irq_edge", irq, WarnEn);
        check_eq("bite_sys_edge", sysrst, !WarnEn);
        wait_cycles(30);
        check_counts("seq", WarnEn ? 4 : 0, 5, 9, 1);
        apb_read(8'hA7, rd); check_eq("seq_status", rd, 8'h11);

        // ACK 0x5A cancels during WARN; without WARN it is ignored.
        snap();
        pulse_bite();
        apb_write(8'hA8, 8'h5A);
        check_eq("ack_irq_low", irq, 1'b0);
        wait_cycles(20);
        check_counts("ack5a", WarnEn ? 2 : 0, WarnEn ? 0 : 5, WarnEn ? 0 : 9, 1);

        snap();
        pulse_bite();
        apb_write(8'hA8, 8'h33);
        wait_cycles(30);
        check_counts("ack33", WarnEn ? 4 : 0, 5, 9, 1);

        // Software reset with HOLD=0.
        apb_write(8'hA7, 8'h00);
        apb_read(8'hA7, rd); check_eq("status_clr1", rd, 8'h00);
        apb_write(8'hA5, 8'h00);
        snap();
        apb_write(8'hA4, 8'h03);
        wait_cycles(20);
        check_counts("swrst", 0, 1, 5, 1);
        apb_read(8'hA7, rd); check_eq("swrst_status", rd, 8'h02);
        apb_read(8'hA4, rd); check_eq("swrst_ctrl", rd, 8'h01);

        // seq_en=0: bites only counted, count saturates.
        apb_write(8'hA4, 8'h00);
        snap();
        for (int i = 0; i < 17; i++) begin
            pulse_bite();
            wait_cycles(1);
        end
        wait_cycles(5);
        check_counts("dis", 0, 0, 0, 0);
        apb_read(8'hA7, rd); check_eq("sat_status", rd, 8'hF2);
        apb_write(8'hA7, 8'hFF);
        apb_read(8'hA7, rd); check_eq("status_clr2", rd, 8'h00);

        // Bite and sw_rst on the same edge, then async reset during HOLD.
        apb_write(8'hA4, 8'h01);
        apb_write(8'hA5, 8'h05);
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
        apb.paddr = 8'hA4; apb.pwdata = 8'h03;
        @(posedge clk); #1 apb.penable = 1'b1; bite = 1'b1;
        @(posedge clk); #1 bite = 1'b0;
        check_eq("both_irq", irq, WarnEn);
        check_eq("both_sys", sysrst, !WarnEn);
        @(posedge clk); #1 apb.psel = 1'b0; apb.penable = 1'b0;
        apb_read(8'hA7, rd); check_eq("both_status", rd, 8'h11);
        k = 0;
        while (sysrst !== 1'b1 && k < 20) begin
            wait_cycles(1);
            k++;
        end
        check_eq("hold_reached", sysrst, 1'b1);
        prst_n = 1'b0;
        #1;
        check_outputs_zero("async");
        wait_cycles(2);
        prst_n = 1'b1;
        wait_cycles(1);
        check_reset_regs("post");
        check_outputs_zero("post");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
